hwpe_ctrl_mult_sched: RTL

Round-robin scheduler that shares one `hwpe_ctrl_seq_mult` sequential multiplier among `NR` requesters inside an HWPE controller. It accepts one operand pair at a time over a req/gnt handshake and launches it into the multiplier. It returns the product to the winning requester as a one-cycle tagged pulse. Typical users are controller-side address/stride computations that need occasional wide products without one multiplier per user.

---
 rtl/hwpe_ctrl_mult_sched_pkg.sv | 18 +
 rtl/hwpe_ctrl_seq_mult.sv | 44 ++++
 rtl/hwpe_ctrl_mult_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hwpe_ctrl_mult_sched_pkg.sv
// Shared types for the HWPE controller multiplier scheduler: FSM states,
// id width helper and the performance counter type.
package hwpe_ctrl_mult_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    typedef logic [31:0] perf_cnt_t;

    function automatic int id_width(input int nr);
        return (nr > 1) ? $clog2(nr) : 1;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_seq_mult.sv
// Shift-add sequential multiplier: start_i loads operands and retires bit 0,
// one further multiplier bit per cycle; prod_o is exact after AW-1 more cycles.
module hwpe_ctrl_seq_mult #(
    parameter int AW = 8,
    parameter int BW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [AW-1:0]    a_i,
    input  logic [BW-1:0]    b_i,
    output logic [AW+BW-1:0] prod_o
);
    localparam int PW = AW + BW;

    logic [PW-1:0] acc_r;
    logic [AW-1:0] a_sh_r;
    logic [PW-1:0] b_sh_r;

    // Accumulate shifted b while low bits of a remain; idles once a is exhausted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_r  <= '0;
            a_sh_r <= '0;
            b_sh_r <= '0;
        end else if (clear_i) begin
            acc_r  <= '0;
            a_sh_r <= '0;
            b_sh_r <= '0;
        end else if (start_i) begin
            acc_r  <= a_i[0] ? {{AW{1'b0}}, b_i} : '0;
            a_sh_r <= a_i >> 1;
            b_sh_r <= {{AW{1'b0}}, b_i} << 1;
        end else begin
            acc_r  <= a_sh_r[0] ? (acc_r + b_sh_r) : acc_r;
            a_sh_r <= a_sh_r >> 1;
            b_sh_r <= b_sh_r << 1;
        end
    end

    assign prod_o = acc_r;

endmodule

// File: rtl/hwpe_ctrl_mult_sched.sv
// Round-robin scheduler sharing one sequential multiplier among NR requesters.
// Optional perf counters enabled by `define HWPE_CTRL_MULT_SCHED_PERF_EN.
module hwpe_ctrl_mult_sched
    import hwpe_ctrl_mult_sched_pkg::*;
#(
    parameter int NR = 4,
    parameter int AW = 8,
    parameter int BW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [NR-1:0]    req_i,
    input  logic [NR*AW-1:0] a_i,
    input  logic [NR*BW-1:0] b_i,
    output logic [NR-1:0]    gnt_o,
    output logic [NR-1:0]    r_valid_o,
    output logic [AW+BW-1:0] r_prod_o,
`ifdef HWPE_CTRL_MULT_SCHED_PERF_EN
    output logic [31:0]      perf_ops_o,
    output logic [31:0]      perf_wait_o,
`endif
    output logic             busy_o
);
    localparam int IDW = id_width(NR);
    localparam int CW  = $clog2(AW + 1);
    localparam int PW  = AW + BW;

    sched_state_e   state_r, state_s;
    logic [IDW-1:0] last_r, id_r, gnt_idx_s;
    logic [AW-1:0]  a_r, a_sel_s;
    logic [BW-1:0]  b_r, b_sel_s;
    logic [CW-1:0]  cnt_r;
    logic [NR-1:0]  gnt_s, r_valid_r;
    logic [PW-1:0]  r_prod_r, mult_prod_s;
    logic           gnt_any_s, busy_r, mult_start_s, done_next_s;
    int             rr_idx_s;

    // Round-robin pick starting after the last winner; only when free to accept.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        rr_idx_s  = 0;
        a_sel_s   = '0;
        b_sel_s   = '0;
        if (rst_ni && !clear_i && (state_r == ST_IDLE || state_r == ST_DONE)) begin
            for (int k = 1; k <= NR; k++) begin
                rr_idx_s = int'(last_r) + k;
                if (rr_idx_s >= NR) rr_idx_s = rr_idx_s - NR;
                else                rr_idx_s = rr_idx_s;
                if (!gnt_any_s && req_i[rr_idx_s[IDW-1:0]]) begin
                    gnt_any_s = 1'b1;
                    gnt_idx_s = rr_idx_s[IDW-1:0];
                end else begin
                    gnt_any_s = gnt_any_s;
                end
            end
        end else begin
            gnt_any_s = 1'b0;
        end
        for (int k = 0; k < NR; k++) begin
            gnt_s[k] = gnt_any_s && (gnt_idx_s == IDW'(k));
            a_sel_s  = a_sel_s | ({AW{gnt_s[k]}} & a_i[k*AW +: AW]);
            b_sel_s  = b_sel_s | ({BW{gnt_s[k]}} & b_i[k*BW +: BW]);
        end
    end

    // Next-state logic; a grant in DONE overlaps the result cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = gnt_any_s ? ST_START : ST_IDLE;
            ST_START: state_s = ST_BUSY;
            ST_BUSY:  state_s = (cnt_r == CW'(AW - 1)) ? ST_DONE : ST_BUSY;
            ST_DONE:  state_s = gnt_any_s ? ST_START : ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
        if (clear_i) state_s = ST_IDLE;
        else         state_s = state_s;
    end

    assign mult_start_s = (state_r == ST_START) && !clear_i;
    assign done_next_s  = (state_r == ST_BUSY) && (cnt_r == CW'(AW - 1)) && !clear_i;

    // State, operand capture, cycle counter and registered result outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            last_r    <= IDW'(NR - 1);
            id_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            cnt_r     <= '0;
            r_valid_r <= '0;
            r_prod_r  <= '0;
        end else begin
            state_r   <= state_s;
            busy_r    <= (state_s != ST_IDLE);
            if (gnt_any_s) begin
                last_r <= gnt_idx_s;
                id_r   <= gnt_idx_s;
                a_r    <= a_sel_s;
                b_r    <= b_sel_s;
            end
            if (clear_i || state_r != ST_BUSY) cnt_r <= '0;
            else                               cnt_r <= cnt_r + CW'(1);
            r_valid_r <= done_next_s ? ({{(NR-1){1'b0}}, 1'b1} << id_r) : '0;
            if (done_next_s) r_prod_r <= mult_prod_s;
        end
    end

    hwpe_ctrl_seq_mult #(
        .AW (AW),
        .BW (BW)
    ) i_mult (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .start_i (mult_start_s),
        .a_i     (a_r),
        .b_i     (b_r),
        .prod_o  (mult_prod_s)
    );

`ifdef HWPE_CTRL_MULT_SCHED_PERF_EN
    perf_cnt_t ops_r, wait_r;

    // Saturating counts of completed operations and starved request cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ops_r  <= '0;
            wait_r <= '0;
        end else if (clear_i) begin
            ops_r  <= '0;
            wait_r <= '0;
        end else begin
            if (state_r == ST_DONE && ops_r != '1)       ops_r  <= ops_r + 32'd1;
            if ((|req_i) && !gnt_any_s && wait_r != '1) wait_r <= wait_r + 32'd1;
        end
    end

    assign perf_ops_o  = ops_r;
    assign perf_wait_o = wait_r;
`endif

    assign gnt_o     = gnt_s;
    assign r_valid_o = r_valid_r;
    assign r_prod_o  = r_prod_r;
    assign busy_o    = busy_r;

endmodule
